scsi_xfer_sm: RTL and testbench

// - Parametrised SCSI-side transfer sequencer: arbitrates CPU register accesses and DMA byte moves to the SCSI controller.
// - Generates CS/RE/WE/DACK strobes with programmable setup/strobe/hold timing, configurable FIFO lane count and DMA burst limits.
// - Sits between the CPU bus interface, the DMA FIFO (byte/word pointer control) and the SCSI controller chip.

---
 rtl/scsi_xfer_sm.sv | 137 +++++++++++++
 tb/tb_scsi_xfer_sm.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/scsi_xfer_sm.sv
// scsi_xfer_sm: sequences CPU register cycles and DMA byte moves to the SCSI controller
// with programmable setup/strobe/hold timing and a per-grant DMA burst limit.
module scsi_xfer_sm #(
   parameter int LANES      = 4,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1,
   parameter int BURST_LEN  = 8,
   localparam int BW        = $clog2(LANES)
) (
   input  logic          CPUCLK,
   input  logic          RESET_,
   input  logic          CPUREQ,
   input  logic          RW,
   input  logic          DMAENA,
   input  logic          DMADIR,
   input  logic          DREQ_,
   input  logic          FIFOFULL,
   input  logic          FIFOEMPTY,
   input  logic [BW-1:0] BO,
   output logic          SCSI_CS_,
   output logic          RE_,
   output logic          WE_,
   output logic          DACK_,
   output logic          INCBO,
   output logic          INCNI,
   output logic          INCNO,
   output logic          S2F,
   output logic          F2S,
   output logic          S2CPU,
   output logic          CPU2S,
   output logic          DSACK_,
   output logic          BUSY
);
   typedef enum logic [2:0] {IDLE, C_SETUP, C_STROBE, C_HOLD, C_ACK, D_SETUP, D_STROBE, D_HOLD} state_t;
   localparam logic [3:0] S_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] T_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] H_LD = 4'(HOLD_CYC - 1);
   localparam logic [3:0] F_LD = (SETUP_CYC > 0) ? S_LD : T_LD;
   localparam state_t C_FIRST = (SETUP_CYC > 0) ? C_SETUP : C_STROBE;
   localparam state_t D_FIRST = (SETUP_CYC > 0) ? D_SETUP : D_STROBE;
   state_t state, nxt;
   logic [3:0] cnt, cnt_n;
   logic [7:0] bcnt, bcnt_n;
   logic dir, dir_n, rw_q, rw_n, dreq_s1, dreq_s2;
   logic last_ph, bubble, byte_end, more, d_ok, last_n, cpu_n, dma_n;
   assign d_ok     = dir ? !FIFOEMPTY : !FIFOFULL;
   assign last_ph  = (state == D_HOLD) || (HOLD_CYC == 0 && state == D_STROBE);
   // a word pointer just moved: wait one cycle so the FIFO flags reflect it
   assign bubble   = last_ph && cnt == 4'd0 && (INCNI || INCNO);
   assign byte_end = last_ph && cnt == 4'd0 && !bubble;
   assign more     = {1'b0, bcnt} + 9'd1 < 9'(BURST_LEN);
   always_comb begin
      nxt    = state;
      cnt_n  = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      bcnt_n = bcnt;
      dir_n  = dir;
      rw_n   = rw_q;
      case (state)
         IDLE: begin
            bcnt_n = 8'd0;
            if (CPUREQ) begin
               nxt   = C_FIRST;
               cnt_n = F_LD;
               rw_n  = RW;
            end else if (DMAENA && !dreq_s2 && (DMADIR ? !FIFOEMPTY : !FIFOFULL)) begin
               nxt   = D_FIRST;
               cnt_n = F_LD;
               dir_n = DMADIR;
            end
         end
         C_SETUP:  if (cnt == 4'd0) begin nxt = C_STROBE; cnt_n = T_LD; end
         C_STROBE: if (cnt == 4'd0) begin nxt = (HOLD_CYC > 0) ? C_HOLD : C_ACK; cnt_n = H_LD; end
         C_HOLD:   if (cnt == 4'd0) nxt = C_ACK;
         C_ACK:    if (!CPUREQ) nxt = IDLE;
         D_SETUP:  if (cnt == 4'd0) begin nxt = D_STROBE; cnt_n = T_LD; end
         D_STROBE: if (cnt == 4'd0 && HOLD_CYC > 0) begin nxt = D_HOLD; cnt_n = H_LD; end
         default: ;
      endcase
      if (bubble) begin
         nxt   = D_HOLD;
         cnt_n = 4'd0;
      end else if (byte_end) begin
         nxt    = (more && !CPUREQ && DMAENA && !dreq_s2 && d_ok) ? D_FIRST : IDLE;
         cnt_n  = F_LD;
         bcnt_n = (nxt == IDLE) ? 8'd0 : bcnt + 8'd1;
      end
   end
   assign last_n = (nxt == D_HOLD || (HOLD_CYC == 0 && nxt == D_STROBE)) && cnt_n == 4'd0 && !bubble;
   assign cpu_n  = nxt inside {C_SETUP, C_STROBE, C_HOLD, C_ACK};
   assign dma_n  = nxt inside {D_SETUP, D_STROBE, D_HOLD};
   always_ff @(posedge CPUCLK or negedge RESET_) begin
      if (!RESET_) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         bcnt     <= 8'd0;
         dir      <= 1'b0;
         rw_q     <= 1'b0;
         dreq_s1  <= 1'b1;
         dreq_s2  <= 1'b1;
         SCSI_CS_ <= 1'b1;
         RE_      <= 1'b1;
         WE_      <= 1'b1;
         DACK_    <= 1'b1;
         DSACK_   <= 1'b1;
         INCBO    <= 1'b0;
         INCNI    <= 1'b0;
         INCNO    <= 1'b0;
         S2F      <= 1'b0;
         F2S      <= 1'b0;
         S2CPU    <= 1'b0;
         CPU2S    <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         state    <= nxt;
         cnt      <= cnt_n;
         bcnt     <= bcnt_n;
         dir      <= dir_n;
         rw_q     <= rw_n;
         dreq_s1  <= DREQ_;
         dreq_s2  <= dreq_s1;
         SCSI_CS_ <= !(cpu_n && nxt != C_ACK);
         RE_      <= !((nxt == C_STROBE && rw_n) || (nxt == D_STROBE && !dir_n));
         WE_      <= !((nxt == C_STROBE && !rw_n) || (nxt == D_STROBE && dir_n));
         DACK_    <= !dma_n;
         DSACK_   <= nxt != C_ACK;
         INCBO    <= last_n;
         INCNI    <= last_n && BO == {BW{1'b1}} && !dir_n;
         INCNO    <= last_n && BO == {BW{1'b1}} && dir_n;
         S2F      <= dma_n && !dir_n;
         F2S      <= dma_n && dir_n;
         S2CPU    <= cpu_n && rw_n;
         CPU2S    <= cpu_n && !rw_n;
         BUSY     <= nxt != IDLE;
      end
   end
endmodule

// File: tb/tb_scsi_xfer_sm.sv
// tb_scsi_xfer_sm: scoreboard bench for scsi_xfer_sm with a behavioural SCSI controller
// (DREQ_ from a pending-byte count) and a FIFO byte-offset counter driven by INCBO.
module tb_scsi_xfer_sm;
   logic CPUCLK = 1'b0, RESET_ = 1'b0, CPUREQ = 1'b0, RW = 1'b0, DMAENA = 1'b0, DMADIR = 1'b0;
   logic FIFOFULL = 1'b0, FIFOEMPTY = 1'b0, DREQ_;
   logic [1:0] bo = 2'd0, exp_bo = 2'd0;
   logic SCSI_CS_, RE_, WE_, DACK_, INCBO, INCNI, INCNO, S2F, F2S, S2CPU, CPU2S, DSACK_, BUSY;
   typedef struct packed {logic ni; logic no; logic gap;} byte_t;
   byte_t byte_q[$];
   logic [5:0] cpu_q[$];
   int nvec = 0, nerr = 0, req_total = 0, done_cnt = 0, run = 0, base = 0, lat = 0;
   logic idle_seen = 1'b1;

   scsi_xfer_sm #(.LANES(4), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .BURST_LEN(8)) dut (
      .CPUCLK(CPUCLK), .RESET_(RESET_), .CPUREQ(CPUREQ), .RW(RW), .DMAENA(DMAENA), .DMADIR(DMADIR),
      .DREQ_(DREQ_), .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY), .BO(bo),
      .SCSI_CS_(SCSI_CS_), .RE_(RE_), .WE_(WE_), .DACK_(DACK_), .INCBO(INCBO), .INCNI(INCNI),
      .INCNO(INCNO), .S2F(S2F), .F2S(F2S), .S2CPU(S2CPU), .CPU2S(CPU2S), .DSACK_(DSACK_), .BUSY(BUSY));

   always #5 CPUCLK = ~CPUCLK;

   // the controller drops DREQ_ as soon as its final byte is acknowledged
   assign DREQ_ = !((req_total - done_cnt > 1) || ((req_total - done_cnt == 1) && DACK_));

   always @(posedge CPUCLK) if (INCBO) begin
      bo       <= bo + 2'd1;
      done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge CPUCLK) begin : mon
      byte_t e;
      run       <= (!RE_ || !WE_) ? run + 1 : 0;
      idle_seen <= INCBO ? 1'b0 : (idle_seen || !BUSY);
      if (RESET_) begin
         chk("cs_dack_excl", 32'(SCSI_CS_ | DACK_), 32'd1);
         chk("re_we_excl", 32'(RE_ | WE_), 32'd1);
         if (cpu_q.size() > 0) chk("cpu_wave", 32'({SCSI_CS_, RE_, WE_, DSACK_, S2CPU, CPU2S}), 32'(cpu_q.pop_front()));
         if (INCBO) begin
            chk("byte_expected", 32'(byte_q.size() > 0), 32'd1);
            if (byte_q.size() > 0) begin
               e = byte_q.pop_front();
               chk("byte_incni_incno", 32'({INCNI, INCNO}), 32'({e.ni, e.no}));
               chk("byte_rearb_gap", 32'(idle_seen), 32'(e.gap));
               chk("byte_strobe_len", 32'(run), 32'd2);
            end
         end
      end
   end

   task automatic cpu_cycle(input logic rw);
      @(negedge CPUCLK); #1;
      for (int k = 1; k <= 6; k++)
         cpu_q.push_back({k > 4, !(rw && (k == 2 || k == 3)), !(!rw && (k == 2 || k == 3)), k != 5, rw && k <= 5, !rw && k <= 5});
      RW = rw;
      CPUREQ = 1'b1;
      repeat (5) @(negedge CPUCLK);
      #1 CPUREQ = 1'b0;
      repeat (3) @(negedge CPUCLK);
   endtask

   task automatic push_bytes(input int n, input int brk);
      for (int i = 0; i < n; i++) begin
         byte_q.push_back({exp_bo == 2'd3 && !DMADIR, exp_bo == 2'd3 && DMADIR, (i % 8 == 0) || i == brk});
         exp_bo++;
      end
      req_total += n;
   endtask

   task automatic wait_done();
      for (int c = 0; c < 3000 && done_cnt != req_total; c++) @(negedge CPUCLK);
      chk("dma_bytes_done", 32'(done_cnt), 32'(req_total));
      for (int c = 0; c < 50 && BUSY; c++) @(negedge CPUCLK);
      chk("dma_back_idle", 32'(BUSY), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      @(negedge CPUCLK);
      chk("rst_low_outs", 32'({SCSI_CS_, RE_, WE_, DACK_, DSACK_}), 32'h1F);
      chk("rst_high_outs", 32'({INCBO, INCNI, INCNO, S2F, F2S, S2CPU, CPU2S, BUSY}), 32'd0);
      #1 RESET_ = 1'b1;
      cpu_cycle(1'b1);
      cpu_cycle(1'b0);
      DMAENA = 1'b1;
      push_bytes(4, -1);
      wait_done();
      push_bytes(12, -1);
      wait_done();
      base = done_cnt;
      push_bytes(6, 3);
      fork
         wait_done();
         begin
            for (int c = 0; c < 500 && !(done_cnt == base + 2 && !DACK_); c++) @(negedge CPUCLK);
            #1 RW = 1'b1;
            CPUREQ = 1'b1;
            for (int c = 0; c < 100 && DSACK_; c++) @(negedge CPUCLK);
            chk("cpu_dsack_seen", 32'(DSACK_), 32'd0);
            chk("cpu_after_byte3", 32'(done_cnt - base), 32'd3);
            #1 CPUREQ = 1'b0;
         end
      join
      DMADIR = 1'b1;
      FIFOEMPTY = 1'b1;
      push_bytes(2, -1);
      repeat (10) @(negedge CPUCLK);
      chk("empty_no_dack", 32'(DACK_), 32'd1);
      chk("empty_idle", 32'(BUSY), 32'd0);
      #1 FIFOEMPTY = 1'b0;
      lat = 0;
      while (DACK_ && lat < 10) begin
         @(negedge CPUCLK);
         lat++;
      end
      chk("empty_release_lat", 32'(lat <= 3 && !DACK_), 32'd1);
      wait_done();
      DMADIR = 1'b0;
      base = done_cnt;
      push_bytes(1, -1);
      for (int c = 0; c < 50 && RE_; c++) @(negedge CPUCLK);
      chk("rst_test_strobe", 32'({RE_, DACK_}), 32'd0);
      #2 RESET_ = 1'b0;
      #1 chk("rst_async_release", 32'({RE_, DACK_, INCBO}), 32'b110);
      repeat (2) @(negedge CPUCLK);
      byte_q.delete();
      exp_bo--;
      req_total -= 1;
      #1 RESET_ = 1'b1;
      repeat (4) @(negedge CPUCLK);
      chk("post_rst_busy", 32'(BUSY), 32'd0);
      chk("post_rst_no_byte", 32'(done_cnt), 32'(base));
      chk("scoreboard_drained", 32'(byte_q.size() + cpu_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
